// File: rtl/mul_sequencer.sv
// Iterative shift-add multiplier for the EX-stage multiply path.
// Holds the pipeline stall while running and presents a registered 2*WIDTH product with a one-cycle done pulse.
module mul_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic               neg;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_fixed;
    logic [CNT_W-1:0]   cnt;
    logic               accept;

    // Signed operands are reduced to magnitudes; the most negative value maps onto itself,
    // which is exactly its unsigned magnitude.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
        return (s && v[WIDTH-1]) ? -v : v;
    endfunction

    assign accept    = (state == S_IDLE) && start && !flush;
    assign acc_fixed = neg ? -acc : acc;

    assign stall = accept || (state == S_RUN) || (state == S_FIX);
    assign busy  = (state != S_IDLE);
    assign done  = (state == S_DONE) && !flush;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start) state_nxt = S_RUN;
                S_RUN:   if (cnt == LAST_STEP) state_nxt = S_FIX;
                S_FIX:   state_nxt = S_DONE;
                // start is still high for the same instruction here, so it must not restart.
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: all datapath registers are plain flops, so they are all reset to a defined zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            neg       <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
            result_hi <= '0;
            result_lo <= '0;
        end else if (!flush) begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        neg    <= sign & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                        mcand  <= {{WIDTH{1'b0}}, mag(op_a, sign)};
                        mplier <= mag(op_b, sign);
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                S_RUN: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                end
                S_FIX: begin
                    acc       <= acc_fixed;
                    result_hi <= acc_fixed[2*WIDTH-1:WIDTH];
                    result_lo <= acc_fixed[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: directed corner products, flush, mid-op reset,
// back-to-back issue and randomized operands against an arithmetic reference.
module tb_mul_sequencer;

    localparam int WIDTH = 32;
    localparam int LAT   = WIDTH + 2;  // cycle index of the done pulse

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             sign;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             flush;
    logic             stall;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result_lo;
    logic [WIDTH-1:0] result_hi;

    int n_checks = 0;
    int n_fail   = 0;
    logic [2*WIDTH-1:0] last_prod = '0;

    mul_sequencer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .sign      (sign),
        .op_a      (op_a),
        .op_b      (op_b),
        .flush     (flush),
        .stall     (stall),
        .busy      (busy),
        .done      (done),
        .result_lo (result_lo),
        .result_hi (result_hi)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2*WIDTH-1:0] ref_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                   input logic s);
        longint sa;
        longint sb;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return sa * sb;
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    // Called just after a rising edge; that edge opens cycle 0. Returns just after the edge closing cycle 34.
    task automatic run_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s, input bit hold);
        logic [2*WIDTH-1:0] exp;
        exp   = ref_mul(a, b, s);
        start = 1'b1;
        sign  = s;
        op_a  = a;
        op_b  = b;
        for (int cyc = 0; cyc <= LAT; cyc++) begin
            @(negedge clk);
            check("stall", {63'b0, stall}, {63'b0, (cyc < LAT)});
            check("done",  {63'b0, done},  {63'b0, (cyc == LAT)});
            check("busy",  {63'b0, busy},  {63'b0, (cyc != 0)});
            if (cyc == LAT) begin
                check("result", {result_hi, result_lo}, exp);
            end
            @(posedge clk);
            #1;
        end
        last_prod = exp;
        if (!hold) start = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_stall", {63'b0, stall}, 64'd0);
            check("idle_busy",  {63'b0, busy},  64'd0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        sign  = 1'b0;
        op_a  = '0;
        op_b  = '0;
        flush = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", {63'b0, stall}, 64'd0);
        check("rst_busy",  {63'b0, busy},  64'd0);
        check("rst_done",  {63'b0, done},  64'd0);
        check("rst_result", {result_hi, result_lo}, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle_cycles(3);

        // Directed products
        run_mul(32'd7, 32'd6, 1'b0, 1'b0);
        check("7x6", {result_hi, result_lo}, 64'h0000_0000_0000_002A);
        idle_cycles(1);
        run_mul(32'hFFFF_FFFD, 32'd5, 1'b1, 1'b0);
        check("m3x5_s", {result_hi, result_lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        idle_cycles(1);
        run_mul(32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
        check("m3x5_u", {result_hi, result_lo}, 64'h0000_0004_FFFF_FFF1);
        idle_cycles(1);
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check("ffxff_u", {result_hi, result_lo}, 64'hFFFF_FFFE_0000_0001);
        idle_cycles(1);
        run_mul(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
        check("minxmin_s", {result_hi, result_lo}, 64'h4000_0000_0000_0000);
        idle_cycles(1);

        // Back-to-back with start held: second accept happens in cycle 35, done in 69
        run_mul(32'd3, 32'd4, 1'b0, 1'b1);
        run_mul(32'd5, 32'd5, 1'b0, 1'b0);
        check("b2b_25", {result_hi, result_lo}, 64'd25);
        idle_cycles(2);

        // flush has priority over start in IDLE
        start = 1'b1;
        flush = 1'b1;
        op_a  = 32'd9;
        op_b  = 32'd9;
        @(negedge clk);
        check("flush_idle_stall", {63'b0, stall}, 64'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        idle_cycles(1);

        // Flush during cycle 10 of a multiply
        start = 1'b1;
        sign  = 1'b0;
        op_a  = 32'h1234_5678;
        op_b  = 32'h0000_0100;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("flush_busy",  {63'b0, busy},  64'd0);
        check("flush_stall", {63'b0, stall}, 64'd0);
        for (int i = 0; i < LAT; i++) begin
            @(negedge clk);
            check("flush_nodone", {63'b0, done}, 64'd0);
        end
        check("flush_keep", {result_hi, result_lo}, last_prod);
        @(posedge clk);
        #1;

        // Reset in cycle 20 of a multiply, then a full run with start high at release
        start = 1'b1;
        op_a  = 32'd1000;
        op_b  = 32'd1000;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        #1;
        check("midrst_busy",   {63'b0, busy},  64'd0);
        check("midrst_done",   {63'b0, done},  64'd0);
        check("midrst_stall",  {63'b0, stall}, {63'b0, start});
        check("midrst_result", {result_hi, result_lo}, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        run_mul(32'hDEAD_BEEF, 32'hFFFF_FF00, 1'b1, 1'b0);
        idle_cycles(1);

        // Randomized operands and signedness
        for (int t = 0; t < 24; t++) begin
            logic [WIDTH-1:0] a;
            logic [WIDTH-1:0] b;
            logic             s;
            a = $urandom;
            b = $urandom;
            s = 1'($urandom_range(0, 1));
            if (t % 6 == 0) a = 32'h8000_0000;
            if (t % 7 == 0) b = '0;
            run_mul(a, b, s, ($urandom_range(0, 2) == 0));
            if (!start) idle_cycles($urandom_range(0, 3));
        end
        start = 1'b0;
        idle_cycles(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
